fsm_marquee: RTL and testbench
==============================

// Module: fsm_marquee
// PURPOSE
//  Successor to the 5-state switch-driven Moore FSM. Keeps its state graph and Z
//  encoding, and adds parametrised scrolling per-state messages on NUM_DIGITS
//  7-segment digits and a saturating lap counter for completed S0->S3->S4->S0 loops.
//  Sits at board top level: KEY0 pushbutton is the clock, switches drive transitions.
// PARAMETERS
//  NUM_DIGITS  4  number of HEX digits driven; MSG_LEN >= NUM_DIGITS required
//  MSG_LEN     8  chars per state message; messages are space-padded to this length
//  SCROLL_DIV  2  KEY0 edges per one-char scroll step; >= 1
//  CNT_W       4  lap counter width
// PORTS
//  KEY0        in   1                clock, all state changes on its rising edge
//  SW0         in   1                reset, synchronous, active-high
//  SW1..SW4    in   1 each           transition inputs
//  hold        in   1                freeze scrolling (used only with MARQUEE_HOLD_EN)
//  hex         out  NUM_DIGITS*7     segments, digit k at [7k+6:7k], active-low, k=NUM_DIGITS-1 leftmost
//  state       out  3                current state encoding
//  Z           out  2                Moore output
//  scroll_pos  out  $clog2(MSG_LEN)  current window offset
//  laps        out  CNT_W            completed S4->S0 loops, saturating
// BEHAVIOUR
//  Reset (SW0=1 at edge, overrides all else): state=S0, offset=0, div=0, laps=0.
//  Transitions (per edge, listed priority; no match = stay in current state):
//   S0(000): SW4->S1, else SW3->S3          S1(001): SW2->S2
//   S2(010): SW2->S3, else SW3->S1          S3(011): SW1->S4, else SW3->S1
//   S4(100): SW1->S0 (laps+1, held at all-ones), else SW4->S1
//   Illegal 101..111 -> S0 on next edge; no lap increment.
//  Z (combinational from state): S0 00, S1 11, S2 00, S3 10, S4 01, illegal 00.
//  Messages: S0 "ALMO", S1 "S_01", S2 "S_02", S3 "S_03", S4 "S_04", each padded
//   to MSG_LEN; illegal state shows the S0 message.
//  Window: digit k shows msg[(offset + NUM_DIGITS-1-k) mod MSG_LEN]; msg[0] is
//   the first char. Combinational from registered state/offset: 0-cycle latency.
//  Scroll: div counts 0..SCROLL_DIV-1. At div==SCROLL_DIV-1, offset=(offset+1)
//   mod MSG_LEN and div=0. Offset wraps MSG_LEN-1 -> 0.
//  State change at an edge sets offset=0 and div=0, overriding a coincident
//   scroll tick. A self-loop (no transition) is not a change: scrolling continues.
// CONFIGURATION
//  MARQUEE_HOLD_EN defined: hold=1 freezes offset and div; state and laps still update.
//   A state change under hold still zeroes offset and div. Reset overrides hold.
//  MARQUEE_HOLD_EN undefined: hold port present but ignored; scrolling free-runs.
// STRUCTURE
//  fsm_marquee_pkg: state enum (S0..S4 codes), Z encoding constants, space pad
//   constant, message-ROM function msg_char(state, idx).
//  Sub-module marquee_window: div/offset counters plus per-digit char select.
//   One existing ASCII-to-7seg decoder instance per digit in a generate loop.
// TESTING (NUM_DIGITS=4, MSG_LEN=8, SCROLL_DIV=2, CNT_W=2)
//  Reset 1 edge -> state=000, Z=00, hex="ALMO", scroll_pos=0, laps=0.
//  In S0, SW4=1 for 1 edge -> state=001, Z=11, hex="S_01", scroll_pos=0.
//  In S1, all SW=0 for 4 edges -> scroll_pos=2, hex="01  "; 12 more edges -> scroll_pos=0.
//  Loop S0-SW3->S3-SW1->S4-SW1->S0 -> laps=1, Z seq 10,01,00; 4 loops total -> laps=3.
//  Force an offset of 3 in S3, then SW3 (no SW1) -> S1 with scroll_pos=0, hex="S_01".
//  SW0=1 with SW4=1 in S1 -> S0. MARQUEE_HOLD_EN on: hold=1 for 6 edges -> scroll_pos unchanged.

Source files
------------

// File: rtl/fsm_marquee_pkg.sv
// fsm_marquee_pkg: state codes, Z encodings, pad character and message ROM
package fsm_marquee_pkg;
  typedef enum logic [2:0] {S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3, S4 = 3'd4} state_t;
  localparam logic [1:0] Z_S0 = 2'b00;
  localparam logic [1:0] Z_S1 = 2'b11;
  localparam logic [1:0] Z_S2 = 2'b00;
  localparam logic [1:0] Z_S3 = 2'b10;
  localparam logic [1:0] Z_S4 = 2'b01;
  localparam logic [1:0] Z_ILL = 2'b00;
  localparam logic [7:0] SPACE = 8'h20;
  function automatic logic [7:0] msg_char(input logic [2:0] s, input int unsigned idx);
    logic [31:0] m;
    m = s == S1 ? "S_01" : s == S2 ? "S_02" : s == S3 ? "S_03" : s == S4 ? "S_04" : "ALMO";
    return idx < 4 ? m[31 - 8 * idx -: 8] : SPACE;
  endfunction
endpackage

// File: rtl/ascii_7seg.sv
// ascii_7seg: ASCII to active-low 7-segment, seg[0]=a .. seg[6]=g; unknown chars blank
module ascii_7seg (
  input  logic [7:0] ch,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    case (ch)
      "0", "O": seg = 7'h40;
      "1":      seg = 7'h79;
      "2":      seg = 7'h24;
      "3":      seg = 7'h30;
      "4":      seg = 7'h19;
      "A":      seg = 7'h08;
      "L":      seg = 7'h47;
      "M":      seg = 7'h48;
      "S":      seg = 7'h12;
      "_":      seg = 7'h77;
      default:  seg = 7'h7F;
    endcase
  end
endmodule

// File: rtl/fsm_marquee_window.sv
// marquee_window: scroll divider/offset counters and per-digit message window decode
module marquee_window
  import fsm_marquee_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN = 8,
  parameter int SCROLL_DIV = 2,
  localparam int PW = $clog2(MSG_LEN),
  localparam int DW = SCROLL_DIV > 1 ? $clog2(SCROLL_DIV) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    change,
  input  logic                    freeze,
  input  logic [2:0]              state,
  output logic [NUM_DIGITS*7-1:0] hex,
  output logic [PW-1:0]           pos
);
  logic [DW-1:0] div;
  logic tick;
  assign tick = div == DW'(SCROLL_DIV - 1);
  // a state change restarts the message even when a scroll tick coincides
  always_ff @(posedge clk) begin
    if (rst || change) begin
      pos <= '0;
      div <= '0;
    end else if (!freeze) begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) pos <= pos == PW'(MSG_LEN - 1) ? '0 : pos + 1'b1;
    end
  end
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    logic [7:0] ch;
    assign ch = msg_char(state, (int'(pos) + NUM_DIGITS - 1 - k) % MSG_LEN);
    ascii_7seg u_seg (.ch(ch), .seg(hex[7*k +: 7]));
  end
endmodule

// File: rtl/fsm_marquee.sv
// fsm_marquee: switch-driven Moore FSM with scrolling state messages and lap counter; MARQUEE_HOLD_EN enables hold
module fsm_marquee
  import fsm_marquee_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN = 8,
  parameter int SCROLL_DIV = 2,
  parameter int CNT_W = 4
) (
  input  logic                         KEY0,
  input  logic                         SW0,
  input  logic                         SW1,
  input  logic                         SW2,
  input  logic                         SW3,
  input  logic                         SW4,
  input  logic                         hold,
  output logic [NUM_DIGITS*7-1:0]      hex,
  output logic [2:0]                   state,
  output logic [1:0]                   Z,
  output logic [$clog2(MSG_LEN)-1:0]   scroll_pos,
  output logic [CNT_W-1:0]             laps
);
`ifdef MARQUEE_HOLD_EN
  localparam logic HOLD_EN = 1'b1;
`else
  localparam logic HOLD_EN = 1'b0;
`endif
  logic [2:0] nxt;
  logic lap_inc;
  always_comb begin
    nxt = S0;
    case (state)
      S0: nxt = SW4 ? S1 : SW3 ? S3 : S0;
      S1: nxt = SW2 ? S2 : S1;
      S2: nxt = SW2 ? S3 : SW3 ? S1 : S2;
      S3: nxt = SW1 ? S4 : SW3 ? S1 : S3;
      S4: nxt = SW1 ? S0 : SW4 ? S1 : S4;
      default: nxt = S0;
    endcase
  end
  assign lap_inc = state == S4 && SW1;
  assign Z = state == S0 ? Z_S0 : state == S1 ? Z_S1 : state == S2 ? Z_S2 :
             state == S3 ? Z_S3 : state == S4 ? Z_S4 : Z_ILL;
  always_ff @(posedge KEY0) begin
    if (SW0) begin
      state <= S0;
      laps <= '0;
    end else begin
      state <= nxt;
      if (lap_inc && laps != '1) laps <= laps + 1'b1;
    end
  end
  marquee_window #(.NUM_DIGITS(NUM_DIGITS), .MSG_LEN(MSG_LEN), .SCROLL_DIV(SCROLL_DIV)) u_win (
    .clk(KEY0),
    .rst(SW0),
    .change(nxt != state),
    .freeze(hold & HOLD_EN),
    .state(state),
    .hex(hex),
    .pos(scroll_pos)
  );
endmodule

// File: tb/tb_fsm_marquee.sv
// tb_fsm_marquee: random and directed stimulus checked against a behavioural marquee model
module tb_fsm_marquee;
  localparam int ND = 4, ML = 8, SD = 2, CW = 2;
  localparam int LMAX = (1 << CW) - 1;
`ifdef MARQUEE_HOLD_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif
  logic clk = 1'b0, sw0 = 1'b0, sw1 = 1'b0, sw2 = 1'b0, sw3 = 1'b0, sw4 = 1'b0, hold = 1'b0;
  logic [ND*7-1:0] hex;
  logic [2:0] state;
  logic [1:0] Z;
  logic [$clog2(ML)-1:0] scroll_pos;
  logic [CW-1:0] laps;
  int checks = 0, errors = 0;
  int m_st = 0, m_off = 0, m_div = 0, m_laps = 0;
  string msgs[5] = '{"ALMO", "S_01", "S_02", "S_03", "S_04"};
  int zt[5] = '{0, 3, 0, 2, 1};

  fsm_marquee #(.NUM_DIGITS(ND), .MSG_LEN(ML), .SCROLL_DIV(SD), .CNT_W(CW)) dut (
    .KEY0(clk), .SW0(sw0), .SW1(sw1), .SW2(sw2), .SW3(sw3), .SW4(sw4), .hold(hold),
    .hex(hex), .state(state), .Z(Z), .scroll_pos(scroll_pos), .laps(laps)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_on(input byte c);
    case (c)
      "0", "O": return 7'h3F;
      "1": return 7'h06;
      "2": return 7'h5B;
      "3": return 7'h4F;
      "4": return 7'h66;
      "A": return 7'h77;
      "L": return 7'h38;
      "M": return 7'h37;
      "S": return 7'h6D;
      "_": return 7'h08;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [ND*7-1:0] exp_hex();
    logic [ND*7-1:0] e;
    int idx;
    byte c;
    for (int k = 0; k < ND; k++) begin
      idx = (m_off + ND - 1 - k) % ML;
      c = idx < 4 ? msgs[m_st][idx] : " ";
      e[7*k +: 7] = ~seg_on(c);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".state"}, 32'(state), 32'(m_st));
    chk({tag, ".Z"}, 32'(Z), 32'(zt[m_st]));
    chk({tag, ".pos"}, 32'(scroll_pos), 32'(m_off));
    chk({tag, ".laps"}, 32'(laps), 32'(m_laps));
    chk({tag, ".hex"}, 32'(hex), 32'(exp_hex()));
  endtask

  task automatic model(input bit r, s1, s2, s3, s4, h);
    int ns;
    if (r) begin
      m_st = 0; m_off = 0; m_div = 0; m_laps = 0;
      return;
    end
    case (m_st)
      0: ns = s4 ? 1 : s3 ? 3 : 0;
      1: ns = s2 ? 2 : 1;
      2: ns = s2 ? 3 : s3 ? 1 : 2;
      3: ns = s1 ? 4 : s3 ? 1 : 3;
      default: ns = s1 ? 0 : s4 ? 1 : 4;
    endcase
    if (m_st == 4 && s1 && m_laps < LMAX) m_laps++;
    if (ns != m_st) begin
      m_off = 0; m_div = 0;
    end else if (!(h && HOLD_ON)) begin
      m_div++;
      if (m_div == SD) begin
        m_div = 0;
        m_off = (m_off + 1) % ML;
      end
    end
    m_st = ns;
  endtask

  task automatic step(input string tag, input bit r, s1, s2, s3, s4, h);
    @(negedge clk);
    sw0 = r; sw1 = s1; sw2 = s2; sw3 = s3; sw4 = s4; hold = h;
    @(posedge clk);
    model(r, s1, s2, s3, s4, h);
    #1 chk_all(tag);
  endtask

  initial begin
    int p0;
    step("reset", 1, 0, 0, 0, 0, 0);
    chk("reset.hex_almo", 32'(hex), 32'({~seg_on("A"), ~seg_on("L"), ~seg_on("M"), ~seg_on("O")}));
    step("s0_to_s1", 0, 0, 0, 0, 1, 0);
    chk("s1.Z", 32'(Z), 32'(2'b11));
    for (int i = 0; i < 4; i++) step("s1_idle", 0, 0, 0, 0, 0, 0);
    chk("s1.pos2", 32'(scroll_pos), 32'd2);
    chk("s1.hex01", 32'(hex), 32'({~seg_on("0"), ~seg_on("1"), 7'h7F, 7'h7F}));
    for (int i = 0; i < 12; i++) step("s1_idle", 0, 0, 0, 0, 0, 0);
    chk("s1.pos0", 32'(scroll_pos), 32'd0);
    step("reset2", 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step("loop_s3", 0, 0, 0, 1, 0, 0);
      step("loop_s4", 0, 1, 0, 0, 0, 0);
      step("loop_s0", 0, 1, 0, 0, 0, 0);
      if (i == 0) chk("laps1", 32'(laps), 32'd1);
    end
    chk("laps_sat", 32'(laps), 32'd3);
    step("to_s3", 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) step("s3_idle", 0, 0, 0, 0, 0, 0);
    chk("s3.pos3", 32'(scroll_pos), 32'd3);
    step("s3_to_s1", 0, 0, 0, 1, 0, 0);
    chk("s3_to_s1.pos", 32'(scroll_pos), 32'd0);
    step("rst_over_sw4", 1, 0, 0, 0, 1, 0);
    chk("rst_over_sw4.state", 32'(state), 32'd0);
    step("s0_idle", 0, 0, 0, 0, 0, 0);
    p0 = int'(scroll_pos);
    for (int i = 0; i < 6; i++) step("hold", 0, 0, 0, 0, 0, 1);
    if (HOLD_ON) chk("hold.pos", 32'(scroll_pos), 32'(p0));
    for (int i = 0; i < 400; i++)
      step("rand", $urandom_range(0, 19) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), $urandom_range(0, 3) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
